fma_sched: RTL and testbench

- Issue scheduler and pipeline sequencer for the shared FMA datapath (multiply/align, significand add, normalize/round).
- Arbitrates two requesters (0 = scalar FPU issue, 1 = auxiliary requester such as a vector/second-hart port) with round-robin fairness.
- Advances per-stage valid/tag/format state and drives the stage register enables.
- Delivers a tagged result through a valid/ready handshake and supports per-requester flush.

---
 rtl/fma_sched_pkg.sv | 12 +
 rtl/fma_sched_if.sv | 16 +
 rtl/fma_sched_rr_arb2.sv | 27 ++
 rtl/fma_sched.sv | 57 +++++
 tb/tb_fma_sched.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fma_sched_pkg.sv
// fma_sched_pkg: shared widths and pipeline slot type for the FMA issue scheduler
package fma_sched_pkg;
  localparam int TAGW = 5;
  localparam int FMTW = 2;
  localparam int FMA_STAGES = 3;
  typedef struct packed {
    logic valid;
    logic src;
    logic [TAGW-1:0] tag;
    logic [FMTW-1:0] fmt;
  } fma_slot_t;
endpackage

// File: rtl/fma_sched_if.sv
// fma_sched_if: requester, flush, stage-control and result signals of the FMA scheduler
interface fma_sched_if import fma_sched_pkg::*; #(parameter int STAGES = FMA_STAGES);
  logic Req0Valid, Req0Ready, Req1Valid, Req1Ready;
  logic [TAGW-1:0] Req0Tag, Req1Tag, ResTag;
  logic [FMTW-1:0] Req0Fmt, Req1Fmt, AddFmt;
  logic Flush0, Flush1, IssueSel, ResValid, ResReady, ResSrc, Busy;
  logic [STAGES-1:0] StageEn, StageValid;
  modport master (
    output Req0Valid, Req0Tag, Req0Fmt, Req1Valid, Req1Tag, Req1Fmt, Flush0, Flush1, ResReady,
    input Req0Ready, Req1Ready, IssueSel, StageEn, StageValid, AddFmt, ResValid, ResSrc, ResTag, Busy
  );
  modport slave (
    input Req0Valid, Req0Tag, Req0Fmt, Req1Valid, Req1Tag, Req1Fmt, Flush0, Flush1, ResReady,
    output Req0Ready, Req1Ready, IssueSel, StageEn, StageValid, AddFmt, ResValid, ResSrc, ResTag, Busy
  );
endinterface

// File: rtl/fma_sched_rr_arb2.sv
// fma_rr_arb2: two-input round-robin arbiter; masked inputs are ineligible, pointer moves past each winner
module fma_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt,
  output logic       sel
);
  logic [1:0] elig;
  logic ptr, win, sel_q;
  always_comb begin
    elig = req & ~mask;
    win = &elig ? ptr : elig[1];
    gnt = (en & |elig) ? (win ? 2'b10 : 2'b01) : 2'b00;
    sel = |gnt ? win : sel_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= 1'b0;
      sel_q <= 1'b0;
    end else if (|gnt) begin
      ptr <= ~win;
      sel_q <= win;
    end
endmodule

// File: rtl/fma_sched.sv
// fma_sched: issue arbitration and in-order stage sequencing for the shared FMA pipeline
module fma_sched import fma_sched_pkg::*; #(parameter int STAGES = FMA_STAGES) (
  input logic clk,
  input logic reset,
  fma_sched_if.slave bus
);
  localparam int L = STAGES - 1;
  fma_slot_t [STAGES-1:0] s;
  fma_slot_t iss;
  logic [STAGES-1:0] sv, adv;
  logic [1:0] gnt, fl;
  logic sel;
  assign fl = {bus.Flush1, bus.Flush0};
  fma_rr_arb2 u_arb (
    .clk(clk), .rst(reset), .en(adv[0]),
    .req({bus.Req1Valid, bus.Req0Valid}), .mask(fl), .gnt(gnt), .sel(sel)
  );
  // a stage may move when it is empty or everything downstream of it moves
  always_comb begin
    adv[L] = ~sv[L] | bus.ResReady;
    for (int i = L - 1; i >= 0; i--) adv[i] = ~sv[i] | adv[i+1];
  end
  always_comb begin
    iss.valid = |gnt;
    iss.src = sel;
    iss.tag = sel ? bus.Req1Tag : bus.Req0Tag;
    iss.fmt = sel ? bus.Req1Fmt : bus.Req0Fmt;
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    fma_slot_t d, nxt, q;
    if (k == 0) begin : g_in
      assign d = iss;
    end else begin : g_pipe
      assign d = s[k-1];
    end
    // flush kills by owner, whether the op is holding or moving this edge
    always_comb begin
      nxt = adv[k] ? d : s[k];
      nxt.valid = nxt.valid & ~fl[nxt.src];
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) q <= '0;
      else q <= nxt;
    assign s[k] = q;
    assign sv[k] = q.valid;
  end
  assign bus.Req0Ready = gnt[0];
  assign bus.Req1Ready = gnt[1];
  assign bus.IssueSel = sel;
  assign bus.StageEn = adv;
  assign bus.StageValid = sv;
  assign bus.AddFmt = sv[1] ? s[1].fmt : '0;
  assign bus.ResValid = sv[L] & ~fl[s[L].src];
  assign bus.ResSrc = sv[L] & s[L].src;
  assign bus.ResTag = sv[L] ? s[L].tag : '0;
  assign bus.Busy = |sv;
endmodule

// File: tb/tb_fma_sched.sv
// tb_fma_sched: directed scenario bench for the FMA issue scheduler
module tb_fma_sched;
  import fma_sched_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  fma_sched_if bus ();
  fma_sched dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.Req0Valid = 0; bus.Req1Valid = 0; bus.Req0Tag = 0; bus.Req1Tag = 0;
    bus.Req0Fmt = 0; bus.Req1Fmt = 0; bus.Flush0 = 0; bus.Flush1 = 0;
  endtask

  task automatic do_reset;
    idle();
    bus.ResReady = 1;
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus.StageValid !== 3'b000) begin errors++; $display("FAIL reset_stagevalid got %b exp 000", bus.StageValid); end
    checks++; if (bus.ResValid !== 1'b0) begin errors++; $display("FAIL reset_resvalid got %b exp 0", bus.ResValid); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.Busy); end
    checks++; if (bus.ResTag !== 5'd0) begin errors++; $display("FAIL reset_restag got %0h exp 0", bus.ResTag); end
    checks++; if (bus.AddFmt !== 2'd0) begin errors++; $display("FAIL reset_addfmt got %0h exp 0", bus.AddFmt); end
    for (int i = 0; i < 3; i++) begin
      bus.Req0Valid = 1; bus.Req0Tag = 5'(i + 1);
      #1;
      checks++; if (bus.Req0Ready !== 1'b1) begin errors++; $display("FAIL midreset_grant%0d got %b exp 1", i, bus.Req0Ready); end
      if (i < 2) tick();
    end
    @(posedge clk);
    reset = 1;
    bus.Req0Valid = 0;
    #1;
    checks++; if (bus.StageValid !== 3'b000) begin errors++; $display("FAIL midreset_stagevalid got %b exp 000", bus.StageValid); end
    checks++; if (bus.ResValid !== 1'b0) begin errors++; $display("FAIL midreset_resvalid got %b exp 0", bus.ResValid); end
    tick();
    reset = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.ResValid !== 1'b0) begin errors++; $display("FAIL midreset_noresult%0d got %b exp 0", i, bus.ResValid); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy%0d got %b exp 0", i, bus.Busy); end
      tick();
    end
    bus.Req0Valid = 1; bus.Req1Valid = 1;
    #1;
    checks++; if (bus.Req0Ready !== 1'b1) begin errors++; $display("FAIL reset_rrptr_r0 got %b exp 1", bus.Req0Ready); end
    checks++; if (bus.Req1Ready !== 1'b0) begin errors++; $display("FAIL reset_rrptr_r1 got %b exp 0", bus.Req1Ready); end
    idle();
  endtask

  task automatic test_latency;
    do_reset();
    bus.Req0Valid = 1; bus.Req0Tag = 5'd5;
    #1;
    checks++; if (bus.Req0Ready !== 1'b1) begin errors++; $display("FAIL latency_grant got %b exp 1", bus.Req0Ready); end
    checks++; if (bus.IssueSel !== 1'b0) begin errors++; $display("FAIL latency_issuesel got %b exp 0", bus.IssueSel); end
    tick();
    idle();
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++; if (bus.ResValid !== logic'(c == 3)) begin errors++; $display("FAIL latency_resvalid_c%0d got %b exp %b", c, bus.ResValid, c == 3); end
      if (c == 3) begin
        checks++; if (bus.ResTag !== 5'd5) begin errors++; $display("FAIL latency_restag got %0d exp 5", bus.ResTag); end
        checks++; if (bus.ResSrc !== 1'b0) begin errors++; $display("FAIL latency_ressrc got %b exp 0", bus.ResSrc); end
      end
      tick();
    end
  endtask

  task automatic test_fairness;
    int g0, g1, j;
    g0 = 0; g1 = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.Req0Valid = logic'(i < 8); bus.Req1Valid = logic'(i < 8);
      bus.Req0Tag = 5'(i); bus.Req1Tag = 5'(i | 16);
      #1;
      if (i < 8) begin
        checks++; if (bus.Req0Ready !== logic'(i % 2 == 0)) begin errors++; $display("FAIL fair_r0_c%0d got %b exp %b", i, bus.Req0Ready, i % 2 == 0); end
        checks++; if (bus.Req1Ready !== logic'(i % 2 == 1)) begin errors++; $display("FAIL fair_r1_c%0d got %b exp %b", i, bus.Req1Ready, i % 2 == 1); end
        checks++; if (bus.IssueSel !== logic'(i % 2)) begin errors++; $display("FAIL fair_sel_c%0d got %b exp %0d", i, bus.IssueSel, i % 2); end
        g0 += int'(bus.Req0Ready); g1 += int'(bus.Req1Ready);
      end
      if (i >= 3 && i < 11) begin
        j = i - 3;
        checks++; if (bus.ResValid !== 1'b1) begin errors++; $display("FAIL fair_resvalid_c%0d got %b exp 1", i, bus.ResValid); end
        checks++; if (bus.ResTag !== 5'(j % 2 == 1 ? (j | 16) : j)) begin errors++; $display("FAIL fair_restag_c%0d got %0h exp %0h", i, bus.ResTag, j % 2 == 1 ? (j | 16) : j); end
        checks++; if (bus.ResSrc !== logic'(j % 2)) begin errors++; $display("FAIL fair_ressrc_c%0d got %b exp %0d", i, bus.ResSrc, j % 2); end
      end else begin
        checks++; if (bus.ResValid !== 1'b0) begin errors++; $display("FAIL fair_idle_c%0d got %b exp 0", i, bus.ResValid); end
      end
      tick();
    end
    checks++; if (g0 !== 4) begin errors++; $display("FAIL fair_count0 got %0d exp 4", g0); end
    checks++; if (g1 !== 4) begin errors++; $display("FAIL fair_count1 got %0d exp 4", g1); end
    idle();
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.ResReady = logic'(i >= 8);
      bus.Req0Valid = logic'(i <= 8);
      bus.Req0Tag = 5'(i < 3 ? i + 1 : 4);
      #1;
      if (i <= 8) begin
        checks++; if (bus.Req0Ready !== logic'(i < 3 || i == 8)) begin errors++; $display("FAIL bp_ready_c%0d got %b exp %b", i, bus.Req0Ready, i < 3 || i == 8); end
      end
      if (i >= 3 && i <= 7) begin
        checks++; if (bus.ResValid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_c%0d got %b exp 1", i, bus.ResValid); end
        checks++; if (bus.ResTag !== 5'd1) begin errors++; $display("FAIL bp_hold_tag_c%0d got %0d exp 1", i, bus.ResTag); end
        checks++; if (bus.StageValid !== 3'b111) begin errors++; $display("FAIL bp_full_c%0d got %b exp 111", i, bus.StageValid); end
        checks++; if (bus.StageEn !== 3'b000) begin errors++; $display("FAIL bp_stall_en_c%0d got %b exp 000", i, bus.StageEn); end
      end
      if (i >= 8 && i <= 11) begin
        checks++; if (bus.ResValid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid_c%0d got %b exp 1", i, bus.ResValid); end
        checks++; if (bus.ResTag !== 5'(i - 7)) begin errors++; $display("FAIL bp_drain_tag_c%0d got %0d exp %0d", i, bus.ResTag, i - 7); end
      end
      if (i == 8) begin
        checks++; if (bus.StageEn !== 3'b111) begin errors++; $display("FAIL bp_release_en got %b exp 111", bus.StageEn); end
      end
      if (i == 12) begin
        checks++; if (bus.ResValid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", bus.ResValid); end
      end
      tick();
    end
    idle();
  endtask

  task automatic fill_aba(input logic [4:0] ta, input logic [4:0] tb, input logic [4:0] tc);
    bus.Req0Valid = 1; bus.Req0Tag = ta;
    #1;
    checks++; if (bus.Req0Ready !== 1'b1) begin errors++; $display("FAIL flush_issue_a got %b exp 1", bus.Req0Ready); end
    tick();
    bus.Req0Valid = 0; bus.Req1Valid = 1; bus.Req1Tag = tb;
    #1;
    checks++; if (bus.Req1Ready !== 1'b1) begin errors++; $display("FAIL flush_issue_b got %b exp 1", bus.Req1Ready); end
    tick();
    bus.Req1Valid = 0; bus.Req0Valid = 1; bus.Req0Tag = tc;
    #1;
    checks++; if (bus.Req0Ready !== 1'b1) begin errors++; $display("FAIL flush_issue_c got %b exp 1", bus.Req0Ready); end
    tick();
  endtask

  task automatic test_flush;
    do_reset();
    fill_aba(5'd10, 5'd11, 5'd12);
    bus.Req0Tag = 5'd13; bus.Flush0 = 1;
    #1;
    checks++; if (bus.ResValid !== 1'b0) begin errors++; $display("FAIL flush_resvalid got %b exp 0", bus.ResValid); end
    checks++; if (bus.Req0Ready !== 1'b0) begin errors++; $display("FAIL flush_nogrant got %b exp 0", bus.Req0Ready); end
    checks++; if (bus.StageValid !== 3'b111) begin errors++; $display("FAIL flush_prefull got %b exp 111", bus.StageValid); end
    tick();
    idle();
    #1;
    checks++; if (bus.ResValid !== 1'b1) begin errors++; $display("FAIL flush_b_valid got %b exp 1", bus.ResValid); end
    checks++; if (bus.ResTag !== 5'd11) begin errors++; $display("FAIL flush_b_tag got %0d exp 11", bus.ResTag); end
    checks++; if (bus.ResSrc !== 1'b1) begin errors++; $display("FAIL flush_b_src got %b exp 1", bus.ResSrc); end
    checks++; if (bus.StageValid !== 3'b100) begin errors++; $display("FAIL flush_after got %b exp 100", bus.StageValid); end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.ResValid !== 1'b0) begin errors++; $display("FAIL flush_c_gone%0d got %b exp 0", i, bus.ResValid); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL flush_busy%0d got %b exp 0", i, bus.Busy); end
      tick();
    end
  endtask

  task automatic test_flush_both;
    do_reset();
    fill_aba(5'd20, 5'd21, 5'd22);
    bus.Req0Valid = 1; bus.Req1Valid = 1; bus.Flush0 = 1; bus.Flush1 = 1;
    #1;
    checks++; if ({bus.Req1Ready, bus.Req0Ready} !== 2'b00) begin errors++; $display("FAIL flushboth_nogrant got %b exp 00", {bus.Req1Ready, bus.Req0Ready}); end
    checks++; if (bus.ResValid !== 1'b0) begin errors++; $display("FAIL flushboth_resvalid got %b exp 0", bus.ResValid); end
    tick();
    idle();
    #1;
    checks++; if (bus.StageValid !== 3'b000) begin errors++; $display("FAIL flushboth_empty got %b exp 000", bus.StageValid); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL flushboth_busy got %b exp 0", bus.Busy); end
  endtask

  task automatic test_addfmt;
    do_reset();
    bus.Req0Valid = 1; bus.Req0Fmt = 2'b01; bus.Req0Tag = 5'd1;
    #1;
    checks++; if (bus.AddFmt !== 2'b00) begin errors++; $display("FAIL addfmt_c0 got %b exp 00", bus.AddFmt); end
    tick();
    bus.Req0Fmt = 2'b11; bus.Req0Tag = 5'd2;
    #1;
    checks++; if (bus.StageValid[1] !== 1'b0) begin errors++; $display("FAIL addfmt_sv1_c1 got %b exp 0", bus.StageValid[1]); end
    checks++; if (bus.AddFmt !== 2'b00) begin errors++; $display("FAIL addfmt_c1 got %b exp 00", bus.AddFmt); end
    tick();
    idle();
    #1;
    checks++; if (bus.StageValid[1] !== 1'b1) begin errors++; $display("FAIL addfmt_sv1_c2 got %b exp 1", bus.StageValid[1]); end
    checks++; if (bus.AddFmt !== 2'b01) begin errors++; $display("FAIL addfmt_c2 got %b exp 01", bus.AddFmt); end
    tick();
    checks++; if (bus.StageValid[1] !== 1'b1) begin errors++; $display("FAIL addfmt_sv1_c3 got %b exp 1", bus.StageValid[1]); end
    checks++; if (bus.AddFmt !== 2'b11) begin errors++; $display("FAIL addfmt_c3 got %b exp 11", bus.AddFmt); end
    tick();
    checks++; if (bus.StageValid[1] !== 1'b0) begin errors++; $display("FAIL addfmt_sv1_c4 got %b exp 0", bus.StageValid[1]); end
    checks++; if (bus.AddFmt !== 2'b00) begin errors++; $display("FAIL addfmt_c4 got %b exp 00", bus.AddFmt); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fairness();
    test_backpressure();
    test_flush();
    test_flush_both();
    test_addfmt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
